ir_report_decoder: RTL and testbench



---
 rtl/ir_report_decoder.sv | 205 ++++++++++++++++++++
 tb/tb_ir_report_decoder.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ir_report_decoder.sv
// Decodes one blob of a PixArt IR sensor extended-mode report (header, then 4 blobs x 3 bytes).
// Optional `IR_HOLD_LAST_EN: an absent blob keeps the last present-blob x/y/size.
module ir_report_decoder #(
  parameter int unsigned BLOB_SEL     = 0,
  parameter int unsigned HEADER_BYTES = 1,
  parameter int unsigned TIMEOUT      = 255
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       frame_start,
  input  logic       byte_valid,
  input  logic [7:0] byte_data,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic [3:0] size,
  output logic       blob_found,
  output logic       xy_valid,
  output logic       frame_error,
  output logic [7:0] frame_count
);

  localparam int unsigned HdrW = (HEADER_BYTES > 1) ? $clog2(HEADER_BYTES) : 1;
  localparam int unsigned TmoW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [1:0]  SelBlob = 2'(BLOB_SEL);

  typedef enum logic [1:0] {StIdle, StHeader, StBlob, StDone} state_e;

  localparam state_e FirstSt = (HEADER_BYTES == 0) ? StBlob : StHeader;

  state_e            state_q, state_d;
  logic [HdrW-1:0]   hdr_q, hdr_d;
  logic [1:0]        fld_q, fld_d;
  logic [1:0]        blob_q, blob_d;
  logic [TmoW-1:0]   tmo_q, tmo_d;
  logic [7:0]        b0_q, b0_d, b1_q, b1_d, b2_q, b2_d;
  logic [9:0]        x_q, x_d, y_q, y_d;
  logic [3:0]        size_q, size_d;
  logic              found_q, found_d;
  logic              xy_valid_q, xy_valid_d;
  logic              err_q, err_d;
  logic [7:0]        fc_q, fc_d;

  // Parse position after an optional mid-frame restart in the same cycle.
  state_e            st_v;
  logic [HdrW-1:0]   hdr_v;
  logic [1:0]        fld_v;
  logic [1:0]        blob_v;
  logic              absent;

  assign absent = (b0_q == 8'hFF) && (b1_q == 8'hFF) && (b2_q == 8'hFF);

  always_comb begin
    state_d    = state_q;
    hdr_d      = hdr_q;
    fld_d      = fld_q;
    blob_d     = blob_q;
    tmo_d      = tmo_q;
    b0_d       = b0_q;
    b1_d       = b1_q;
    b2_d       = b2_q;
    x_d        = x_q;
    y_d        = y_q;
    size_d     = size_q;
    found_d    = found_q;
    xy_valid_d = 1'b0;
    err_d      = 1'b0;
    fc_d       = fc_q;
    st_v       = state_q;
    hdr_v      = hdr_q;
    fld_v      = fld_q;
    blob_v     = blob_q;

    unique case (state_q)
      StIdle: begin
        if (frame_start) begin
          state_d = FirstSt;
          hdr_d   = '0;
          fld_d   = '0;
          blob_d  = '0;
          tmo_d   = '0;
        end
      end

      StHeader, StBlob: begin
        if (frame_start) begin
          err_d   = 1'b1;
          st_v    = FirstSt;
          hdr_v   = '0;
          fld_v   = '0;
          blob_v  = '0;
          state_d = FirstSt;
          hdr_d   = '0;
          fld_d   = '0;
          blob_d  = '0;
          tmo_d   = '0;
        end

        if (byte_valid) begin
          tmo_d = '0;
          if (st_v == StHeader) begin
            if (int'(hdr_v) == HEADER_BYTES - 1) begin
              state_d = StBlob;
              hdr_d   = '0;
            end else begin
              hdr_d = hdr_v + 1'b1;
            end
          end else begin
            if (blob_v == SelBlob) begin
              unique case (fld_v)
                2'd0:    b0_d = byte_data;
                2'd1:    b1_d = byte_data;
                default: b2_d = byte_data;
              endcase
            end
            if (fld_v == 2'd2) begin
              fld_d  = '0;
              blob_d = blob_v + 1'b1;
              if (blob_v == 2'd3) begin
                state_d = StDone;
              end
            end else begin
              fld_d = fld_v + 1'b1;
            end
          end
        end else if (!frame_start) begin
          if (tmo_q == TmoW'(TIMEOUT - 1)) begin
            err_d   = 1'b1;
            state_d = StIdle;
          end else begin
            tmo_d = tmo_q + 1'b1;
          end
        end
      end

      StDone: begin
        xy_valid_d = 1'b1;
        fc_d       = fc_q + 1'b1;
        found_d    = !absent;
        state_d    = StIdle;
        if (!absent) begin
          x_d    = {b2_q[5:4], b0_q};
          y_d    = {b2_q[7:6], b1_q};
          size_d = b2_q[3:0];
        end else begin
`ifdef IR_HOLD_LAST_EN
          x_d    = x_q;
          y_d    = y_q;
          size_d = size_q;
`else
          x_d    = '1;
          y_d    = '1;
          size_d = '1;
`endif
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= StIdle;
      hdr_q      <= '0;
      fld_q      <= '0;
      blob_q     <= '0;
      tmo_q      <= '0;
      b0_q       <= 8'hFF;
      b1_q       <= 8'hFF;
      b2_q       <= 8'hFF;
      x_q        <= '1;
      y_q        <= '1;
      size_q     <= '1;
      found_q    <= 1'b0;
      xy_valid_q <= 1'b0;
      err_q      <= 1'b0;
      fc_q       <= '0;
    end else begin
      state_q    <= state_d;
      hdr_q      <= hdr_d;
      fld_q      <= fld_d;
      blob_q     <= blob_d;
      tmo_q      <= tmo_d;
      b0_q       <= b0_d;
      b1_q       <= b1_d;
      b2_q       <= b2_d;
      x_q        <= x_d;
      y_q        <= y_d;
      size_q     <= size_d;
      found_q    <= found_d;
      xy_valid_q <= xy_valid_d;
      err_q      <= err_d;
      fc_q       <= fc_d;
    end
  end

  assign x           = x_q;
  assign y           = y_q;
  assign size        = size_q;
  assign blob_found  = found_q;
  assign xy_valid    = xy_valid_q;
  assign frame_error = err_q;
  assign frame_count = fc_q;

endmodule

// File: tb/tb_ir_report_decoder.sv
// Randomized bench for ir_report_decoder: two instances (blob 0 and blob 2) share one stimulus
// stream and are checked against a frame-level reference model.
module tb_ir_report_decoder;

  localparam int unsigned Timeout = 255;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       frame_start = 1'b0;
  logic       byte_valid = 1'b0;
  logic [7:0] byte_data = 8'h00;

  logic [9:0] x0, y0, x2, y2;
  logic [3:0] size0, size2;
  logic       found0, found2, xyv0, xyv2, err0, err2;
  logic [7:0] fc0, fc2;

  int vectors = 0;
  int miscompares = 0;
  int xy_cnt [2] = '{0, 0};
  int err_cnt [2] = '{0, 0};
  int frames = 0;

  logic [7:0] frm [13];
  int exp_x [2], exp_y [2], exp_size [2], exp_found [2];
  int exp_fc;
  int sel [2] = '{0, 2};

  always #5 clk = ~clk;

  ir_report_decoder #(.BLOB_SEL(0), .HEADER_BYTES(1), .TIMEOUT(Timeout)) dut0 (
    .clk(clk), .reset_n(reset_n), .frame_start(frame_start), .byte_valid(byte_valid),
    .byte_data(byte_data), .x(x0), .y(y0), .size(size0), .blob_found(found0),
    .xy_valid(xyv0), .frame_error(err0), .frame_count(fc0)
  );

  ir_report_decoder #(.BLOB_SEL(2), .HEADER_BYTES(1), .TIMEOUT(Timeout)) dut2 (
    .clk(clk), .reset_n(reset_n), .frame_start(frame_start), .byte_valid(byte_valid),
    .byte_data(byte_data), .x(x2), .y(y2), .size(size2), .blob_found(found2),
    .xy_valid(xyv2), .frame_error(err2), .frame_count(fc2)
  );

  always @(negedge clk) begin
    if (xyv0) xy_cnt[0]++;
    if (xyv2) xy_cnt[1]++;
    if (err0) err_cnt[0]++;
    if (err2) err_cnt[1]++;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic void model_reset();
    for (int d = 0; d < 2; d++) begin
      exp_x[d] = 1023;
      exp_y[d] = 1023;
      exp_size[d] = 15;
      exp_found[d] = 0;
    end
    exp_fc = 0;
  endfunction

  // Frame-level model: pick the selected blob's three bytes and apply the decode arithmetic.
  function automatic void model_update();
    for (int d = 0; d < 2; d++) begin
      int b0, b1, b2;
      b0 = int'(frm[1 + 3 * sel[d]]);
      b1 = int'(frm[2 + 3 * sel[d]]);
      b2 = int'(frm[3 + 3 * sel[d]]);
      if (b0 == 255 && b1 == 255 && b2 == 255) begin
        exp_found[d] = 0;
`ifndef IR_HOLD_LAST_EN
        exp_x[d] = 1023;
        exp_y[d] = 1023;
        exp_size[d] = 15;
`endif
      end else begin
        exp_found[d] = 1;
        exp_x[d] = ((b2 / 16) % 4) * 256 + b0;
        exp_y[d] = (b2 / 64) * 256 + b1;
        exp_size[d] = b2 % 16;
      end
    end
    exp_fc = (exp_fc + 1) % 256;
    frames++;
  endfunction

  task automatic check_outputs(input string tag);
    check_val({tag, " x0"}, 32'(x0), exp_x[0]);
    check_val({tag, " y0"}, 32'(y0), exp_y[0]);
    check_val({tag, " size0"}, 32'(size0), exp_size[0]);
    check_val({tag, " found0"}, 32'(found0), exp_found[0]);
    check_val({tag, " fc0"}, 32'(fc0), exp_fc);
    check_val({tag, " x2"}, 32'(x2), exp_x[1]);
    check_val({tag, " y2"}, 32'(y2), exp_y[1]);
    check_val({tag, " size2"}, 32'(size2), exp_size[1]);
    check_val({tag, " found2"}, 32'(found2), exp_found[1]);
    check_val({tag, " fc2"}, 32'(fc2), exp_fc);
  endtask

  task automatic drive(input logic fs, input logic bv, input logic [7:0] bd);
    @(negedge clk);
    frame_start = fs;
    byte_valid = bv;
    byte_data = bd;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 1'b0, 8'h00);
  endtask

  task automatic start_frame();
    drive(1'b1, 1'b0, 8'h00);
  endtask

  task automatic send_bytes(input int from, input int to, input int gap_max);
    for (int i = from; i <= to; i++) begin
      repeat ($urandom_range(gap_max, 0)) drive(1'b0, 1'b0, 8'h00);
      drive(1'b0, 1'b1, frm[i]);
    end
  endtask

  // Called right after the last byte was driven: pulse must appear one cycle after acceptance.
  task automatic finish_frame(input string tag);
    model_update();
    drive(1'b0, 1'b0, 8'h00);
    check_val({tag, " early xy_valid"}, 32'(xyv0), 0);
    drive(1'b0, 1'b0, 8'h00);
    check_val({tag, " xy_valid0"}, 32'(xyv0), 1);
    check_val({tag, " xy_valid2"}, 32'(xyv2), 1);
    check_outputs(tag);
    drive(1'b0, 1'b0, 8'h00);
    check_val({tag, " xy_valid width"}, 32'(xyv0), 0);
  endtask

  function automatic void set_ff();
    for (int i = 0; i < 13; i++) frm[i] = 8'hFF;
    frm[0] = 8'h00;
  endfunction

  function automatic void random_frame();
    frm[0] = 8'($urandom);
    for (int k = 0; k < 4; k++) begin
      bit gone;
      gone = ($urandom_range(3, 0) == 0);
      for (int f = 0; f < 3; f++) frm[1 + 3 * k + f] = gone ? 8'hFF : 8'($urandom);
    end
  endfunction

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int n;
    bit seen;
    model_reset();
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    idle(100);
    check_outputs("reset");
    check_val("reset xy_valid count", 32'(xy_cnt[0] + xy_cnt[1]), 0);

    set_ff();
    frm[1] = 8'h34;
    frm[2] = 8'h12;
    frm[3] = 8'h9A;
    start_frame();
    send_bytes(0, 12, 0);
    finish_frame("blob0");

    random_frame();
    frm[7] = 8'hFF;
    frm[8] = 8'hFF;
    frm[9] = 8'h05;
    start_frame();
    send_bytes(0, 12, 1);
    finish_frame("blob2 ff ff 05");

    set_ff();
    start_frame();
    send_bytes(0, 12, 1);
    finish_frame("blob2 absent");

    random_frame();
    frm[7] = 8'h21;
    frm[8] = 8'h43;
    frm[9] = 8'hC6;
    start_frame();
    send_bytes(0, 12, 1);
    finish_frame("blob2 present");
    set_ff();
    start_frame();
    send_bytes(0, 12, 0);
    finish_frame("blob2 absent again");

    // Timeout after byte 5
    random_frame();
    start_frame();
    send_bytes(0, 5, 0);
    n = 0;
    seen = 1'b0;
    while (n < 400 && !seen) begin
      drive(1'b0, 1'b0, 8'h00);
      n++;
      if (err0) seen = 1'b1;
    end
    check_val("timeout cycles", 32'(n), Timeout + 1);
    check_val("timeout err2", 32'(err2), 1);
    drive(1'b0, 1'b0, 8'h00);
    check_val("timeout err width", 32'(err0), 0);
    idle(2);
    check_outputs("after timeout");
    check_val("timeout no xy_valid", 32'(xy_cnt[0]), frames);

    random_frame();
    start_frame();
    send_bytes(0, 12, 2);
    finish_frame("frame after timeout");

    // Restart at byte 7
    random_frame();
    start_frame();
    send_bytes(0, 6, 1);
    drive(1'b1, 1'b0, 8'h00);
    random_frame();
    send_bytes(0, 12, 1);
    finish_frame("restart");

    // Restart with byte 0 in the same cycle
    random_frame();
    start_frame();
    send_bytes(0, 6, 1);
    random_frame();
    drive(1'b1, 1'b1, frm[0]);
    send_bytes(1, 12, 1);
    finish_frame("restart byte0");
    idle(2);
    check_val("error pulses dut0", 32'(err_cnt[0]), 3);
    check_val("error pulses dut2", 32'(err_cnt[1]), 3);

    for (int i = 0; i < 256; i++) begin
      random_frame();
      if ($urandom_range(3, 0) == 0) drive(1'b0, 1'b1, 8'($urandom));
      start_frame();
      send_bytes(0, 12, ($urandom_range(1, 0) == 0) ? 0 : 3);
      finish_frame($sformatf("rand%0d", i));
    end
    check_val("error pulses after random", 32'(err_cnt[0]), 3);

    // Asynchronous reset mid-frame
    random_frame();
    start_frame();
    send_bytes(0, 4, 0);
    #2;
    reset_n = 1'b0;
    #1;
    model_reset();
    check_outputs("async reset");
    check_val("async reset xy_valid", 32'(xyv0), 0);
    check_val("async reset err", 32'(err0), 0);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    random_frame();
    start_frame();
    send_bytes(0, 12, 1);
    finish_frame("post reset");
    idle(2);
    check_val("total xy pulses dut0", 32'(xy_cnt[0]), frames);
    check_val("total xy pulses dut2", 32'(xy_cnt[1]), frames);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
